// File: rtl/femto_bus_fabric_if.sv
// femto_bus_fabric_if: CPU-side and peripheral-side signals of the femto
// interconnect bundled together. The master modport is the fabric's view: it
// drives the slave strobes and the CPU response. The slave modport is the view
// of the surrounding environment, meaning the CPU and the peripheral ports.
interface femto_bus_fabric_if #(
    parameter int unsigned NSLAVES = 4
);
    // CPU side
    logic [31:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_wmask;
    logic                   mem_rstrb;
    logic [31:0]            mem_rdata;
    logic                   mem_rbusy;
    logic                   mem_wbusy;
    // peripheral side
    logic [NSLAVES-1:0]     s_rd;
    logic [NSLAVES-1:0]     s_wr;
    logic [31:0]            s_wdata;
    logic [NSLAVES*32-1:0]  s_rdata;
    logic [NSLAVES-1:0]     s_rbusy;
    logic [NSLAVES-1:0]     s_wbusy;
    // error reporting
    logic                   err_clr;
    logic                   err_flag;
    logic [31:0]            err_addr;

    modport master (
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata, mem_rbusy, mem_wbusy,
        output s_rd, s_wr, s_wdata,
        input  s_rdata, s_rbusy, s_wbusy,
        input  err_clr,
        output err_flag, err_addr
    );

    modport slave (
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata, mem_rbusy, mem_wbusy,
        input  s_rd, s_wr, s_wdata,
        output s_rdata, s_rbusy, s_wbusy,
        output err_clr,
        input  err_flag, err_addr
    );
endinterface

// File: rtl/femto_bus_fabric.sv
// femto_bus_fabric: parametrised CPU-to-peripheral interconnect.
// Decodes mem_addr[31:16] against NSLAVES page numbers. It issues same-cycle
// read/write strobes and then waits for the selected slave's busy to drop.
// A watchdog forces completion after TIMEOUT wait cycles and logs the address.
// Optional build macro STRICT_DECODE_EN: unmatched pages select no slave and
// complete at once with an error. Without it, they route to DEFAULT_SLAVE.
module femto_bus_fabric #(
    parameter int unsigned               NSLAVES       = 4,
    parameter logic [16*NSLAVES-1:0]     SLAVE_BASE    = 64'h0042_0041_0040_0000,
    parameter int unsigned               DEFAULT_SLAVE = 0,
    parameter int unsigned               TIMEOUT       = 255,
    parameter logic [31:0]               ERR_RDATA     = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              resetn,
    femto_bus_fabric_if.master bus
);

    localparam int unsigned IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               err_flag_q, err_flag_d;
    logic [31:0]        err_addr_q, err_addr_d;

    logic [IDX_W-1:0]   idx;
    logic               hit;
    logic               route;
    logic               miss;
    logic               wr_req;
    logic               rd_req;
    logic               wait_busy;
    logic               timeout;
    logic               done;
    logic               err_set;
    logic [NSLAVES-1:0] onehot;
    logic [31:0]        sel_rdata;

`ifdef STRICT_DECODE_EN
    logic               miss_q, miss_d;
    assign route = hit;
    assign miss  = miss_q;
`else
    assign route = 1'b1;
    assign miss  = 1'b0;
`endif

    assign sel_rdata    = bus.s_rdata[32*sel_q +: 32];
    assign bus.err_flag = err_flag_q;
    assign bus.err_addr = err_addr_q;

    // Page decode: walking down from the top slot leaves the lowest match in idx.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        hit = 1'b0;
        idx = IDX_W'(DEFAULT_SLAVE);
        for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
            if (bus.mem_addr[31:16] == SLAVE_BASE[16*i +: 16]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

    // Next-state logic for the transaction FSM, the watchdog and the error log.
    always_comb begin
        wr_req    = |bus.mem_wmask;
        rd_req    = bus.mem_rstrb & ~wr_req;
        onehot    = '0;
        onehot[idx] = 1'b1;
        wait_busy = (state_q == RD_WAIT) ? bus.s_rbusy[sel_q] : bus.s_wbusy[sel_q];
        timeout   = (cnt_q == 16'(TIMEOUT));
        // A slave dropping busy in the timeout cycle still counts as a normal completion.
        err_set   = (state_q != IDLE) && (miss || (wait_busy && timeout));
        done      = (state_q != IDLE) && (miss || !wait_busy || timeout);

        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef STRICT_DECODE_EN
        miss_d  = miss_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr_req || rd_req) begin
                    state_d = wr_req ? WR_WAIT : RD_WAIT;
                    sel_d   = idx;
                    addr_d  = bus.mem_addr;
`ifdef STRICT_DECODE_EN
                    miss_d  = ~hit;
`endif
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new error beats a coincident clear, and then it also refreshes the logged address.
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (err_set) begin
            err_flag_d = 1'b1;
            if (!err_flag_q || bus.err_clr) begin
                err_addr_d = addr_q;
            end
        end else if (bus.err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    // Combinational CPU/slave outputs, forced to zero while reset is asserted.
    always_comb begin
        bus.s_rd      = '0;
        bus.s_wr      = '0;
        bus.s_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_rbusy = 1'b0;
        bus.mem_wbusy = 1'b0;
        if (resetn) begin
            bus.s_wdata   = bus.mem_wdata;
            bus.mem_rdata = sel_rdata;
            if (state_q == IDLE && route) begin
                if (wr_req) begin
                    bus.s_wr = onehot;
                end else if (rd_req) begin
                    bus.s_rd = onehot;
                end
            end
            if (state_q == RD_WAIT) begin
                bus.mem_rbusy = ~done;
                if (miss) begin
                    bus.mem_rdata = '0;
                end else if (wait_busy && timeout) begin
                    bus.mem_rdata = ERR_RDATA;
                end
            end
            if (state_q == WR_WAIT) begin
                bus.mem_wbusy = ~done;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state_q    <= IDLE;
            sel_q      <= IDX_W'(DEFAULT_SLAVE);
            addr_q     <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
`ifdef STRICT_DECODE_EN
            miss_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
`ifdef STRICT_DECODE_EN
            miss_q     <= miss_d;
`endif
        end
    end

endmodule

// File: tb/tb_femto_bus_fabric.sv
// tb_femto_bus_fabric: directed scenarios with literal expectations, then
// randomized traffic. A transaction-level reference model checks every cycle.
module tb_femto_bus_fabric;

    localparam int          NS      = 4;
    localparam int          TMO     = 8;
    localparam int          DEF     = 0;
    localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;
`ifdef STRICT_DECODE_EN
    localparam bit          STRICT  = 1'b1;
`else
    localparam bit          STRICT  = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;

    femto_bus_fabric_if #(.NSLAVES(NS)) bus ();

    femto_bus_fabric #(
        .NSLAVES       (NS),
        .SLAVE_BASE    (64'h0042_0041_0040_0000),
        .DEFAULT_SLAVE (DEF),
        .TIMEOUT       (TMO),
        .ERR_RDATA     (ERR_VAL)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] page_of(input int i);
        case (i)
            0:       return 16'h0000;
            1:       return 16'h0040;
            2:       return 16'h0041;
            default: return 16'h0042;
        endcase
    endfunction

    // ---------------- reference model: one outstanding transaction ----------------
    int          m_mode;   // 0 none, 1 read pending, 2 write pending
    int          m_sel;
    logic [31:0] m_addr;
    int          m_wait;
    bit          m_miss;
    bit          m_errf;
    logic [31:0] m_erra;

    always @(negedge clk) begin : model_cmp
        logic [3:0]  e_rd, e_wr;
        logic [31:0] e_rdata, e_wdata;
        bit          e_rb, e_wb, done, err, hit, start, busy;
        int          idx;
        e_rd = '0; e_wr = '0; e_rb = 0; e_wb = 0;
        done = 0; err = 0; start = 0; hit = 0; idx = DEF;
        e_rdata = '0; e_wdata = '0;
        if (!resetn) begin
            m_mode = 0; m_sel = DEF; m_addr = '0; m_wait = 0;
            m_miss = 0; m_errf = 0; m_erra = '0;
        end else begin
            for (int i = NS - 1; i >= 0; i--) begin
                if (bus.mem_addr[31:16] == page_of(i)) begin
                    hit = 1; idx = i;
                end
            end
            e_wdata = bus.mem_wdata;
            e_rdata = bus.s_rdata[32*m_sel +: 32];
            if (m_mode == 0) begin
                if (|bus.mem_wmask || bus.mem_rstrb) begin
                    start = 1;
                    if (hit || !STRICT) begin
                        if (|bus.mem_wmask) e_wr[idx] = 1'b1;
                        else                e_rd[idx] = 1'b1;
                    end
                end
            end else begin
                busy = (m_mode == 1) ? bus.s_rbusy[m_sel] : bus.s_wbusy[m_sel];
                if (m_miss) begin
                    done = 1; err = 1;
                    if (m_mode == 1) e_rdata = '0;
                end else if (!busy) begin
                    done = 1;
                end else if (m_wait == TMO) begin
                    done = 1; err = 1;
                    if (m_mode == 1) e_rdata = ERR_VAL;
                end else if (m_mode == 1) begin
                    e_rb = 1;
                end else begin
                    e_wb = 1;
                end
            end
        end

        check("m_s_rd",      32'(bus.s_rd),      32'(e_rd));
        check("m_s_wr",      32'(bus.s_wr),      32'(e_wr));
        check("m_s_wdata",   bus.s_wdata,        e_wdata);
        check("m_rdata",     bus.mem_rdata,      e_rdata);
        check("m_rbusy",     32'(bus.mem_rbusy), 32'(e_rb));
        check("m_wbusy",     32'(bus.mem_wbusy), 32'(e_wb));
        check("m_err_flag",  32'(bus.err_flag),  32'(m_errf));
        check("m_err_addr",  bus.err_addr,       m_erra);

        if (resetn) begin
            if (err) begin
                if (!m_errf || bus.err_clr) m_erra = m_addr;
                m_errf = 1;
            end else if (bus.err_clr) begin
                m_errf = 0;
            end
            if (start) begin
                m_mode = (|bus.mem_wmask) ? 2 : 1;
                m_sel  = idx;
                m_addr = bus.mem_addr;
                m_wait = 0;
                m_miss = STRICT && !hit;
            end else if (done) begin
                m_mode = 0;
            end else if (m_mode != 0) begin
                m_wait++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.mem_wmask = '0;
        bus.mem_rstrb = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic set_rdata(input int s, input logic [31:0] v);
        bus.s_rdata[32*s +: 32] = v;
    endtask

    // Issue a read and count busy cycles until completion; returns at the
    // completion cycle's sample point.
    task automatic read_until_done(input logic [31:0] addr, output int n);
        bus.mem_addr  = addr;
        bus.mem_rstrb = 1'b1;
        sample();
        step();
        bus.mem_rstrb = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (!bus.mem_rbusy) break;
            n++;
            step();
        end
        check("read_bound", 32'(n < 40), 32'd1);
    endtask

    initial begin : stim
        int n;
        resetn        = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.s_rdata   = '0;
        bus.s_rbusy   = '0;
        bus.s_wbusy   = '0;
        quiet();
        sample();
        check("rst_err_flag", 32'(bus.err_flag), 32'd0);
        check("rst_rbusy",    32'(bus.mem_rbusy), 32'd0);
        step();
        step();
        resetn = 1'b1;

        // 1: read slave0 with three busy cycles
        bus.mem_addr = 32'h0000_0010;
        bus.mem_rstrb = 1'b1;
        set_rdata(0, 32'h1234_5678);
        sample();
        check("t1_strobe", 32'(bus.s_rd), 32'h1);
        step();
        bus.mem_rstrb = 1'b0;
        bus.s_rbusy[0] = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            sample();
            if (bus.mem_rbusy) n++;
            if (k == 0) check("t1_pulse", 32'(bus.s_rd), 32'h0);
            step();
        end
        bus.s_rbusy[0] = 1'b0;
        sample();
        check("t1_busy_cycles", 32'(n), 32'd3);
        check("t1_rdata", bus.mem_rdata, 32'h1234_5678);
        check("t1_err", 32'(bus.err_flag), 32'd0);
        step();

        // 2: byte write to slave1 with two busy cycles
        bus.mem_addr  = 32'h0040_0000;
        bus.mem_wdata = 32'h41;
        bus.mem_wmask = 4'b0001;
        sample();
        check("t2_s_wr", 32'(bus.s_wr), 32'h2);
        check("t2_s_rd", 32'(bus.s_rd), 32'h0);
        check("t2_wdata", bus.s_wdata, 32'h41);
        step();
        bus.mem_wmask = '0;
        bus.s_wbusy[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 2; k++) begin
            sample();
            if (bus.mem_wbusy) n++;
            step();
        end
        bus.s_wbusy[1] = 1'b0;
        sample();
        check("t2_busy_cycles", 32'(n), 32'd2);
        check("t2_wbusy_end", 32'(bus.mem_wbusy), 32'd0);
        step();

        // 3: watchdog on a stuck slave3, then a second timeout, then clear
        bus.s_rbusy[3] = 1'b1;
        set_rdata(3, 32'h3333_3333);
        read_until_done(32'h0042_0000, n);
        check("t3_wait_cycles", 32'(n), 32'd8);
        check("t3_err_rdata", bus.mem_rdata, 32'hFFFF_FFFF);
        step();
        sample();
        check("t3_err_flag", 32'(bus.err_flag), 32'd1);
        check("t3_err_addr", bus.err_addr, 32'h0042_0000);
        step();
        bus.s_rbusy[2] = 1'b1;
        read_until_done(32'h0041_0000, n);
        check("t3b_wait_cycles", 32'(n), 32'd8);
        step();
        sample();
        check("t3b_err_addr", bus.err_addr, 32'h0042_0000);
        step();
        bus.err_clr = 1'b1;
        sample();
        step();
        bus.err_clr = 1'b0;
        bus.s_rbusy = '0;
        sample();
        check("t3_clr_flag", 32'(bus.err_flag), 32'd0);
        check("t3_clr_addr", bus.err_addr, 32'h0042_0000);
        step();

        // 4: unmatched page
        bus.mem_addr = 32'h0099_0004;
        bus.mem_rstrb = 1'b1;
        set_rdata(0, 32'h55AA_55AA);
        sample();
`ifdef STRICT_DECODE_EN
        check("t4_no_strobe", 32'(bus.s_rd), 32'h0);
`else
        check("t4_default_strobe", 32'(bus.s_rd), 32'h1);
`endif
        step();
        bus.mem_rstrb = 1'b0;
        sample();
`ifdef STRICT_DECODE_EN
        check("t4_rdata_zero", bus.mem_rdata, 32'h0);
`else
        check("t4_rdata", bus.mem_rdata, 32'h55AA_55AA);
`endif
        step();
        sample();
`ifdef STRICT_DECODE_EN
        check("t4_err_flag", 32'(bus.err_flag), 32'd1);
        check("t4_err_addr", bus.err_addr, 32'h0099_0004);
`else
        check("t4_no_err", 32'(bus.err_flag), 32'd0);
`endif
        step();

        // 5: reset in the middle of a read, then a clean read of slave2
        bus.mem_addr = 32'h0041_0000;
        bus.mem_wdata = 32'hA5A5_A5A5;
        bus.mem_rstrb = 1'b1;
        bus.s_rbusy[2] = 1'b1;
        set_rdata(0, 32'hDEAD_BEEF);
        sample();
        check("t5_strobe", 32'(bus.s_rd), 32'h4);
        step();
        bus.mem_rstrb = 1'b0;
        sample();
        check("t5_waiting", 32'(bus.mem_rbusy), 32'd1);
        step();
        resetn = 1'b0;
        bus.mem_rstrb = 1'b1;
        sample();
        check("t5_rst_rbusy", 32'(bus.mem_rbusy), 32'd0);
        check("t5_rst_rdata", bus.mem_rdata, 32'h0);
        check("t5_rst_s_rd", 32'(bus.s_rd), 32'h0);
        check("t5_rst_wdata", bus.s_wdata, 32'h0);
        check("t5_rst_err", 32'(bus.err_flag), 32'd0);
        step();
        resetn = 1'b1;
        bus.s_rbusy = '0;
        set_rdata(2, 32'hCAFE_0002);
        sample();
        check("t5_re_strobe", 32'(bus.s_rd), 32'h4);
        step();
        bus.mem_rstrb = 1'b0;
        sample();
        check("t5_re_rdata", bus.mem_rdata, 32'hCAFE_0002);
        step();

        // 6: simultaneous read and write, then a read during WR_WAIT
        bus.mem_addr = 32'h0000_0020;
        bus.mem_rstrb = 1'b1;
        bus.mem_wmask = 4'hF;
        sample();
        check("t6_s_wr", 32'(bus.s_wr), 32'h1);
        check("t6_s_rd", 32'(bus.s_rd), 32'h0);
        step();
        bus.mem_wmask = '0;
        bus.s_wbusy[0] = 1'b1;
        sample();
        check("t6_no_rd", 32'(bus.s_rd), 32'h0);
        check("t6_wbusy", 32'(bus.mem_wbusy), 32'd1);
        step();
        quiet();
        bus.s_wbusy = '0;
        sample();
        check("t6_wbusy_end", 32'(bus.mem_wbusy), 32'd0);
        step();

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            resetn = ($urandom_range(0, 299) != 0);
            case ($urandom_range(0, 5))
                0, 1, 2, 3: bus.mem_addr = {page_of($urandom_range(0, 3)), 16'($urandom)};
                4:          bus.mem_addr = {16'h0099, 16'($urandom)};
                default:    bus.mem_addr = $urandom;
            endcase
            bus.mem_wdata = $urandom;
            bus.mem_wmask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.mem_rstrb = ($urandom_range(0, 2) == 0);
            bus.err_clr   = ($urandom_range(0, 15) == 0);
            for (int s = 0; s < NS; s++) begin
                set_rdata(s, $urandom);
                bus.s_rbusy[s] = ($urandom_range(0, 3) != 0);
                bus.s_wbusy[s] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        resetn = 1'b1;
        quiet();
        sample();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/femto_bus_fabric.md
Name: femto_bus_fabric

Overview:
Parametrised CPU-to-peripheral interconnect for the femto SoC, replacing the fixed 7-way case decoder and read mux. It decodes mem_addr[31:16] against NSLAVES configurable page numbers and issues one-cycle read/write strobes to the selected slave. It tracks each transaction in a small FSM and aggregates per-slave busy into mem_rbusy/mem_wbusy. A watchdog terminates stalled transactions and logs the failing address.

Parameters:
NSLAVES, 4, number of slave ports (1..16)
SLAVE_BASE, 64'h0042_0041_0040_0000, packed NSLAVES x 16-bit page numbers; slot i = bits [16*i+15:16*i]
DEFAULT_SLAVE, 0, slave index used for unmatched pages
TIMEOUT, 255, max wait cycles before forced completion (1..65535)
ERR_RDATA, 32'hFFFF_FFFF, read data returned on timeout

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data, forwarded unchanged on s_wdata
mem_wmask  in  4  byte write mask; nonzero = write request
mem_rstrb  in  1  one-cycle read request
mem_rdata  out  32  read data to CPU
mem_rbusy  out  1  read in progress
mem_wbusy  out  1  write in progress
s_rd  out  NSLAVES  one-hot read strobe
s_wr  out  NSLAVES  one-hot write strobe
s_wdata  out  32  write data to slaves
s_rdata  in  NSLAVES*32  packed slave read data
s_rbusy  in  NSLAVES  per-slave read busy
s_wbusy  in  NSLAVES  per-slave write busy
err_clr  in  1  clears err_flag
err_flag  out  1  sticky error flag
err_addr  out  32  address of the first unacknowledged error

Behaviour:
- Reset: all outputs 0, FSM=IDLE, sel_q=DEFAULT_SLAVE, timeout counter 0.
- Decode is combinational. idx = lowest i with mem_addr[31:16]==SLAVE_BASE slot i. If no slot matches, idx = DEFAULT_SLAVE.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE with |mem_wmask: s_wr[idx]=1 in the same cycle; latch sel_q=idx and addr_q; go to WR_WAIT.
- IDLE with mem_rstrb (and no write): s_rd[idx]=1 in the same cycle; latch sel_q and addr_q; go to RD_WAIT.
- Write and read requested in the same cycle: the write wins and the read is dropped. This is not an error.
- RD_WAIT:
  - mem_rbusy = s_rbusy[sel_q].
  - mem_rdata = s_rdata[sel_q], muxed from the latched index; outside RD_WAIT the mux still uses sel_q.
  - When s_rbusy[sel_q]==0, the transaction completes and the FSM returns to IDLE.
  - Minimum latency: data is valid in the first cycle after rstrb.
- WR_WAIT: mem_wbusy = s_wbusy[sel_q]. Return to IDLE when that busy is 0.
- Requests that arrive outside IDLE are ignored (no strobe, no queueing).
- Watchdog:
  - The counter clears on entry to RD_WAIT/WR_WAIT and increments each wait cycle.
  - On reaching TIMEOUT, that cycle is forced as completion: busy=0, mem_rdata=ERR_RDATA (reads), FSM returns to IDLE.
  - err_flag is set and err_addr=addr_q, captured only if err_flag was 0.
- err_clr clears err_flag (err_addr holds its value). If err_clr coincides with a new error, the set wins and err_addr is updated.
- Reset asserted mid-transaction: immediate return to reset values. Slaves must tolerate an abandoned strobe.

Optional Feature:
STRICT_DECODE_EN
- Defined: unmatched pages select no slave. s_rd/s_wr stay all-zero. The access completes in one cycle with mem_rdata=0, and err_flag/err_addr are set as for a timeout.
- Undefined: unmatched pages route to DEFAULT_SLAVE with no error, matching legacy decoder behaviour.

Test Plan:
1. Read 0x0000_0010; slave0 holds rbusy 3 cycles with s_rdata=0x1234_5678 -> s_rd[0] pulses 1 cycle, mem_rbusy high 3 cycles, then mem_rdata=0x1234_5678, err_flag=0.
2. Write wmask=4'b0001, wdata=0x41 to 0x0040_0000; slave1 wbusy 2 cycles -> s_wr[1] one pulse, s_wdata=0x41, mem_wbusy high 2 cycles, no other strobes.
3. Read 0x0042_0000 with slave3 rbusy stuck high, TIMEOUT=8 -> completion after 8 wait cycles, mem_rdata=0xFFFF_FFFF, err_flag=1, err_addr=0x0042_0000. A second timeout leaves err_addr unchanged. err_clr then drops err_flag.
4. Read 0x0099_0004 -> without STRICT_DECODE_EN: s_rd[0] pulses, no error. With it: no strobe, mem_rdata=0, err_flag=1, err_addr=0x0099_0004.
5. Assert resetn low during RD_WAIT -> all outputs 0 immediately. After release, a read to slave2 completes normally.
6. mem_rstrb and wmask=4'hF in the same cycle -> only s_wr strobes, FSM=WR_WAIT. A rstrb during WR_WAIT produces no s_rd.
